// File: rtl/sprite_pkg.sv
// Shared sprite table entry, FSM state encoding and default canvas/frame geometry.
// Pure declarations; no logic or latency of its own.
// SPRITE_ANIM_EN adds per-entry animation length storage to the entry struct.
package sprite_pkg;

    // Default geometry shared with the rendering side.
    localparam int DEF_MAX_SPRITES   = 16;
    localparam int DEF_CANVAS_WIDTH  = 360;
    localparam int DEF_CANVAS_HEIGHT = 720;
    localparam int DEF_FRAME_WIDTH   = 64;
    localparam int DEF_FRAME_HEIGHT  = 64;
    localparam int DEF_NUM_FRAMES    = 512;
    localparam int DEF_ANIM_SHIFT    = 2;

    // Field widths of a stored table entry.
    localparam int SPR_X_W = $clog2(DEF_CANVAS_WIDTH);
    localparam int SPR_Y_W = $clog2(DEF_CANVAS_HEIGHT);
    localparam int SPR_F_W = $clog2(DEF_NUM_FRAMES);
    localparam int FC_W    = 6;

    // Dispatcher walk states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } sprite_state_e;

    // One sprite table entry.
    typedef struct packed {
        logic               active;
        logic [SPR_X_W-1:0] x;
        logic [SPR_Y_W-1:0] y;
        logic [SPR_F_W-1:0] base_frame;
`ifdef SPRITE_ANIM_EN
        logic [1:0]         anim_log2;
`endif
    } sprite_entry_t;

    // Animation step within a 2^anim_log2 frame loop, advanced every 2^shift video frames.
    function automatic logic [FC_W-1:0] anim_offset(input logic [FC_W-1:0] fc,
                                                    input logic [1:0]      anim_log2,
                                                    input int              shift);
        logic [FC_W-1:0] mask;
        mask = (FC_W'(1) << anim_log2) - FC_W'(1);
        return (fc >> shift) & mask;
    endfunction

endpackage

// File: rtl/sprite_dispatcher.sv
// Walks the sprite table once per video frame and issues each drawable sprite to the renderer.
// Latency: walk starts 1 cycle after frame_count changes; >=1 SCAN cycle between issued sprites.
// Backpressure: sprite_valid holds with stable outputs until sprite_ready; optional macro SPRITE_ANIM_EN.
module sprite_dispatcher
    import sprite_pkg::*;
#(
    parameter int MAX_SPRITES         = DEF_MAX_SPRITES,
    parameter int CANVAS_WIDTH        = DEF_CANVAS_WIDTH,
    parameter int CANVAS_HEIGHT       = DEF_CANVAS_HEIGHT,
    parameter int SPRITE_FRAME_WIDTH  = DEF_FRAME_WIDTH,
    parameter int SPRITE_FRAME_HEIGHT = DEF_FRAME_HEIGHT,
    parameter int NUM_FRAMES          = DEF_NUM_FRAMES,
    parameter int ANIM_SHIFT          = DEF_ANIM_SHIFT
) (
    input  logic                              clk_pixel,
    input  logic                              sys_rst,
    input  logic [5:0]                        frame_count,
    input  logic                              sprite_ready,
    input  logic                              tbl_we,
    input  logic [$clog2(MAX_SPRITES)-1:0]    tbl_addr,
    input  logic                              tbl_active,
    input  logic [$clog2(CANVAS_WIDTH)-1:0]   tbl_x,
    input  logic [$clog2(CANVAS_HEIGHT)-1:0]  tbl_y,
    input  logic [$clog2(NUM_FRAMES)-1:0]     tbl_base_frame,
    input  logic [1:0]                        tbl_anim_log2,
    output logic                              sprite_valid,
    output logic [$clog2(CANVAS_WIDTH)-1:0]   sprite_x,
    output logic [$clog2(CANVAS_HEIGHT)-1:0]  sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0]     sprite_frame_number,
    output logic                              busy,
    output logic                              overrun,
    output logic [$clog2(MAX_SPRITES+1)-1:0]  issued_count
);

    localparam int IDX_W = $clog2(MAX_SPRITES);
    localparam int X_W   = $clog2(CANVAS_WIDTH);
    localparam int Y_W   = $clog2(CANVAS_HEIGHT);
    localparam int F_W   = $clog2(NUM_FRAMES);
    localparam int CNT_W = $clog2(MAX_SPRITES + 1);

    // Largest top-left corner that still keeps the whole frame on the canvas.
    localparam logic [X_W-1:0]   X_LIM    = X_W'(CANVAS_WIDTH - SPRITE_FRAME_WIDTH);
    localparam logic [Y_W-1:0]   Y_LIM    = Y_W'(CANVAS_HEIGHT - SPRITE_FRAME_HEIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SPRITES - 1);

    sprite_entry_t     tbl [MAX_SPRITES];
    sprite_entry_t     cur;
    sprite_state_e     state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  run_cnt;
    logic [5:0]        prev_fc;
    logic              fc_change;
    logic              fits;
    logic              xfer;
    logic              is_last;
    logic [F_W-1:0]    frame_next;

`ifndef SPRITE_ANIM_EN
    // Animation length has no storage in the static-frame build.
    logic unused_anim;
    assign unused_anim = ^tbl_anim_log2;
`endif

    assign cur       = tbl[idx];
    assign fc_change = (frame_count != prev_fc);
    assign xfer      = sprite_valid && sprite_ready;
    assign is_last   = (idx == LAST_IDX);

    // Decide whether the entry under the scan index is drawable and what frame it shows.
    always_comb begin
        fits = cur.active && (cur.x <= X_LIM) && (cur.y <= Y_LIM);
`ifdef SPRITE_ANIM_EN
        frame_next = cur.base_frame
                   + F_W'(anim_offset(frame_count, cur.anim_log2, ANIM_SHIFT));
`else
        frame_next = cur.base_frame;
`endif
    end

    // Table storage: only the active bits are reset, payload fields are don't-care until written.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            for (int i = 0; i < MAX_SPRITES; i++) begin
                tbl[i].active <= 1'b0;
            end
        end else if (tbl_we) begin
            tbl[tbl_addr].active     <= tbl_active;
            tbl[tbl_addr].x          <= tbl_x;
            tbl[tbl_addr].y          <= tbl_y;
            tbl[tbl_addr].base_frame <= tbl_base_frame;
`ifdef SPRITE_ANIM_EN
            tbl[tbl_addr].anim_log2  <= tbl_anim_log2;
`endif
        end
    end

    // Walk FSM: a new video frame restarts the walk; issued sprites are latched so
    // later table writes never disturb what the consumer is looking at.
    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            state               <= ST_IDLE;
            idx                 <= '0;
            run_cnt             <= '0;
            prev_fc             <= frame_count;
            sprite_valid        <= 1'b0;
            sprite_x            <= '0;
            sprite_y            <= '0;
            sprite_frame_number <= '0;
            busy                <= 1'b0;
            overrun             <= 1'b0;
            issued_count        <= '0;
        end else begin
            prev_fc <= frame_count;
            if (fc_change && busy) begin
                // Frame ended before the walk did: abandon it and start over.
                // A handshake completing this cycle has already been taken by the consumer.
                overrun      <= 1'b1;
                state        <= ST_SCAN;
                idx          <= '0;
                run_cnt      <= '0;
                sprite_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fc_change) begin
                            state   <= ST_SCAN;
                            idx     <= '0;
                            run_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (fits) begin
                            sprite_x            <= cur.x;
                            sprite_y            <= cur.y;
                            sprite_frame_number <= frame_next;
                            sprite_valid        <= 1'b1;
                            state               <= ST_ISSUE;
                        end else if (is_last) begin
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        if (xfer) begin
                            sprite_valid <= 1'b0;
                            run_cnt      <= run_cnt + 1'b1;
                            if (is_last) begin
                                state <= ST_DONE;
                            end else begin
                                state <= ST_SCAN;
                                idx   <= idx + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        issued_count <= run_cnt;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_dispatcher.sv
// Directed bench for sprite_dispatcher: single-entry vector table plus multi-cycle corner sequences.
// Expected values are hand-computed; transfers are logged at the falling edge.
// Works with or without SPRITE_ANIM_EN.
module tb_sprite_dispatcher;

    logic       clk_pixel = 1'b0;
    logic       sys_rst;
    logic [5:0] frame_count;
    logic       sprite_ready;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic       tbl_active;
    logic [8:0] tbl_x;
    logic [9:0] tbl_y;
    logic [8:0] tbl_base_frame;
    logic [1:0] tbl_anim_log2;
    logic       sprite_valid;
    logic [8:0] sprite_x;
    logic [9:0] sprite_y;
    logic [8:0] sprite_frame_number;
    logic       busy;
    logic       overrun;
    logic [4:0] issued_count;

    sprite_dispatcher dut (
        .clk_pixel           (clk_pixel),
        .sys_rst             (sys_rst),
        .frame_count         (frame_count),
        .sprite_ready        (sprite_ready),
        .tbl_we              (tbl_we),
        .tbl_addr            (tbl_addr),
        .tbl_active          (tbl_active),
        .tbl_x               (tbl_x),
        .tbl_y               (tbl_y),
        .tbl_base_frame      (tbl_base_frame),
        .tbl_anim_log2       (tbl_anim_log2),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .busy                (busy),
        .overrun             (overrun),
        .issued_count        (issued_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic [8:0] x;
        logic [9:0] y;
        logic [8:0] f;
    } xfer_t;

    typedef struct {
        logic [3:0] addr;
        logic       active;
        logic [8:0] x;
        logic [9:0] y;
        logic [8:0] base;
        logic [1:0] alog;
        logic [5:0] fc;
        int         exp_xfers;
        logic [8:0] exp_frame;
    } vec_t;

    xfer_t log_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    gap_viol = 0;
    logic  prev_xfer = 1'b0;

    // Transfer log and back-to-back valid detector, sampled mid-cycle.
    always @(negedge clk_pixel) begin
        if (!sys_rst) begin
            if (prev_xfer && sprite_valid) gap_viol++;
            prev_xfer = sprite_valid && sprite_ready;
            if (sprite_valid && sprite_ready)
                log_q.push_back('{x: sprite_x, y: sprite_y, f: sprite_frame_number});
        end else begin
            prev_xfer = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic reset_pulse();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
    endtask

    task automatic write_entry(input logic [3:0] a, input logic act, input logic [8:0] x,
                               input logic [9:0] y, input logic [8:0] b, input logic [1:0] al);
        tbl_we = 1'b1; tbl_addr = a; tbl_active = act;
        tbl_x = x; tbl_y = y; tbl_base_frame = b; tbl_anim_log2 = al;
        step();
        tbl_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 400 && busy; n++) step();
        check(name, busy, 0);
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < 100 && !sprite_valid; n++) step();
        check(name, sprite_valid, 1);
    endtask

    vec_t vecs[8];

    initial begin
        int base_len;

        // addr act  x    y    base alog fc  xfers frame(anim / static)
        vecs[0] = '{4'd0, 1'b1,  9'd10,  10'd20, 9'd5,   2'd0, 6'd1,  1, 9'd5};
        vecs[1] = '{4'd5, 1'b1,  9'd296, 10'd656, 9'd17, 2'd0, 6'd2,  1, 9'd17};
        vecs[2] = '{4'd0, 1'b1,  9'd297, 10'd0,  9'd1,   2'd0, 6'd3,  0, 9'd0};
        vecs[3] = '{4'd15, 1'b1, 9'd0,   10'd657, 9'd1,  2'd0, 6'd4,  0, 9'd0};
        vecs[4] = '{4'd1, 1'b1,  9'd300, 10'd20, 9'd2,   2'd0, 6'd5,  0, 9'd0};
        vecs[5] = '{4'd2, 1'b0,  9'd10,  10'd20, 9'd2,   2'd0, 6'd6,  0, 9'd0};
`ifdef SPRITE_ANIM_EN
        vecs[6] = '{4'd15, 1'b1, 9'd0,   10'd0,  9'd511, 2'd3, 6'd29, 1, 9'd6};
        vecs[7] = '{4'd4, 1'b1,  9'd7,   10'd9,  9'd8,   2'd2, 6'd13, 1, 9'd11};
`else
        vecs[6] = '{4'd15, 1'b1, 9'd0,   10'd0,  9'd511, 2'd3, 6'd29, 1, 9'd511};
        vecs[7] = '{4'd4, 1'b1,  9'd7,   10'd9,  9'd8,   2'd2, 6'd13, 1, 9'd8};
`endif

        sys_rst = 1'b1; frame_count = 6'd0; sprite_ready = 1'b1;
        tbl_we = 1'b0; tbl_addr = '0; tbl_active = 1'b0; tbl_x = '0; tbl_y = '0;
        tbl_base_frame = '0; tbl_anim_log2 = '0;
        step(); step();
        sys_rst = 1'b0;

        check("rst_valid", sprite_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_issued", issued_count, 0);
        check("rst_xyf", {sprite_x, sprite_y, sprite_frame_number}, 0);

        // Single-entry vectors: boundary, off-canvas, inactive, frame number.
        for (int i = 0; i < 8; i++) begin
            reset_pulse();
            write_entry(vecs[i].addr, vecs[i].active, vecs[i].x, vecs[i].y,
                        vecs[i].base, vecs[i].alog);
            base_len = log_q.size();
            frame_count = vecs[i].fc;
            step();
            check($sformatf("v%0d_busy_rise", i), busy, 1);
            wait_idle($sformatf("v%0d_done", i));
            check($sformatf("v%0d_xfers", i), log_q.size() - base_len, vecs[i].exp_xfers);
            check($sformatf("v%0d_issued", i), issued_count, vecs[i].exp_xfers);
            if (vecs[i].exp_xfers == 1 && log_q.size() > base_len) begin
                check($sformatf("v%0d_x", i), log_q[base_len].x, vecs[i].x);
                check($sformatf("v%0d_y", i), log_q[base_len].y, vecs[i].y);
                check($sformatf("v%0d_frame", i), log_q[base_len].f, vecs[i].exp_frame);
            end
        end

        // Two active entries, consumer always ready.
        reset_pulse();
        write_entry(4'd0, 1'b1, 9'd10, 10'd20, 9'd5, 2'd0);
        write_entry(4'd3, 1'b1, 9'd100, 10'd200, 9'd40, 2'd0);
        base_len = log_q.size();
        frame_count = 6'd1;
        step();
        wait_idle("two_done");
        check("two_xfers", log_q.size() - base_len, 2);
        if (log_q.size() - base_len == 2) begin
            check("two_first", log_q[base_len], {9'd10, 10'd20, 9'd5});
            check("two_second", log_q[base_len+1], {9'd100, 10'd200, 9'd40});
        end
        check("two_issued", issued_count, 2);
        check("two_overrun", overrun, 0);

        // Consumer stalls for 50 cycles; a rewrite of the latched entry must not leak out.
        reset_pulse();
        write_entry(4'd2, 1'b1, 9'd50, 10'd60, 9'd7, 2'd0);
        sprite_ready = 1'b0;
        base_len = log_q.size();
        frame_count = 6'd2;
        step();
        wait_valid("stall_valid");
        for (int c = 0; c < 50; c++) begin
            if (c == 10) write_entry(4'd2, 1'b1, 9'd1, 10'd1, 9'd1, 2'd0);
            else step();
            check($sformatf("stall_hold%0d", c),
                  {sprite_valid, sprite_x, sprite_y, sprite_frame_number},
                  {1'b1, 9'd50, 10'd60, 9'd7});
        end
        check("stall_no_xfer", log_q.size() - base_len, 0);
        sprite_ready = 1'b1;
        step();
        check("stall_xfer", log_q.size() - base_len, 1);
        check("stall_drop", sprite_valid, 0);
        wait_idle("stall_done");
        check("stall_issued", issued_count, 1);

        // Frame change while the second of three sprites is pending.
        reset_pulse();
        write_entry(4'd0, 1'b1, 9'd10, 10'd20, 9'd1, 2'd0);
        write_entry(4'd1, 1'b1, 9'd20, 10'd30, 9'd2, 2'd0);
        write_entry(4'd2, 1'b1, 9'd30, 10'd40, 9'd3, 2'd0);
        sprite_ready = 1'b0;
        frame_count = 6'd3;
        step();
        wait_valid("ovr_first_valid");
        sprite_ready = 1'b1;
        step();
        sprite_ready = 1'b0;
        wait_valid("ovr_second_valid");
        check("ovr_second_x", sprite_x, 20);
        check("ovr_before", overrun, 0);
        frame_count = 6'd4;
        step();
        check("ovr_set", overrun, 1);
        check("ovr_drop", sprite_valid, 0);
        base_len = log_q.size();
        sprite_ready = 1'b1;
        wait_idle("ovr_done");
        check("ovr_xfers", log_q.size() - base_len, 3);
        if (log_q.size() - base_len == 3) begin
            check("ovr_x0", log_q[base_len].x, 10);
            check("ovr_x1", log_q[base_len+1].x, 20);
            check("ovr_x2", log_q[base_len+2].x, 30);
        end
        check("ovr_issued", issued_count, 3);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of an issue: drops valid, clears the table.
        reset_pulse();
        write_entry(4'd0, 1'b1, 9'd10, 10'd20, 9'd5, 2'd0);
        sprite_ready = 1'b0;
        frame_count = 6'd5;
        step();
        wait_valid("rst_mid_valid");
        sys_rst = 1'b1;
        step();
        check("rst_mid_drop", sprite_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_overrun", overrun, 0);
        sys_rst = 1'b0;
        sprite_ready = 1'b1;
        base_len = log_q.size();
        frame_count = 6'd6;
        step();
        wait_idle("rst_mid_walk1");
        frame_count = 6'd7;
        step();
        wait_idle("rst_mid_walk2");
        check("rst_mid_no_xfer", log_q.size() - base_len, 0);
        check("rst_mid_issued", issued_count, 0);

        check("valid_gap", gap_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_dispatcher.md
SPRITE_DISPATCHER -- requirements
Module: sprite_dispatcher

Interface
REQ-001 SHALL have parameter MAX_SPRITES, default 16, meaning number of sprite table entries.
REQ-002 SHALL have parameter CANVAS_WIDTH, default 360, and CANVAS_HEIGHT, default 720, meaning the drawable canvas in pixels.
REQ-003 SHALL have parameter SPRITE_FRAME_WIDTH, default 64, and SPRITE_FRAME_HEIGHT, default 64, meaning the sprite frame size.
REQ-004 SHALL have parameter NUM_FRAMES, default 512, meaning total spritesheet frames; ANIM_SHIFT, default 2, meaning the frame_count right-shift per animation step.
REQ-005 SHALL have ports: clk_pixel in 1 pixel clock; sys_rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: frame_count in 6 video frame counter; sprite_ready in 1 consumer idle/ready.
REQ-007 SHALL have table write ports: tbl_we in 1; tbl_addr in clog2(MAX_SPRITES); tbl_active in 1; tbl_x in clog2(CANVAS_WIDTH); tbl_y in clog2(CANVAS_HEIGHT); tbl_base_frame in clog2(NUM_FRAMES); tbl_anim_log2 in 2 (animation length 2^n frames).
REQ-008 SHALL have outputs: sprite_valid 1; sprite_x clog2(CANVAS_WIDTH); sprite_y clog2(CANVAS_HEIGHT); sprite_frame_number clog2(NUM_FRAMES); busy 1 walk in progress; overrun 1 sticky; issued_count clog2(MAX_SPRITES+1) sprites issued in the last completed walk.

Function
REQ-009 SHALL hold the table in registers; a write with tbl_we=1 updates entry tbl_addr at the clock edge; the entry is readable the next cycle.
REQ-010 SHALL register frame_count into prev_fc each cycle; frame_count != prev_fc in cycle t SHALL move the FSM from IDLE to SCAN at t+1 with index 0, and set busy=1.
REQ-011 SHALL implement states IDLE, SCAN, ISSUE, DONE.
REQ-012 In SCAN, one entry per cycle: if the entry is active and x <= CANVAS_WIDTH-SPRITE_FRAME_WIDTH and y <= CANVAS_HEIGHT-SPRITE_FRAME_HEIGHT, SHALL latch x, y, and frame number and go to ISSUE; otherwise skip it. After index MAX_SPRITES-1, SHALL go to DONE.
REQ-013 In ISSUE, sprite_valid SHALL be 1 and the outputs stable; a transfer occurs in a cycle with sprite_valid && sprite_ready.
REQ-014 After a transfer, SHALL deassert sprite_valid next cycle, increment the running count, and return to SCAN at index+1, or go to DONE if the index was last.
REQ-015 sprite_valid SHALL never be high in two consecutive cycles spanning a transfer; the minimum gap is 1 cycle.
REQ-016 DONE SHALL last 1 cycle: it copies the running count to issued_count, clears busy, and returns to IDLE.
REQ-017 A frame_count change while busy SHALL set overrun=1, drop sprite_valid, and restart SCAN at index 0 with the running count cleared; an in-flight transfer in that same cycle counts as complete.
REQ-018 A table write to the latched entry during ISSUE SHALL NOT alter the presented outputs.
REQ-019 All arithmetic SHALL be unsigned; the frame number addition SHALL wrap modulo 2^clog2(NUM_FRAMES).

Reset
REQ-020 On sys_rst, SHALL clear every table entry's active bit, state=IDLE, sprite_valid=0, sprite_x/y/frame_number=0, busy=0, overrun=0, issued_count=0, prev_fc=frame_count.
REQ-021 Reset asserted mid-walk SHALL take effect on the next edge with no further transfers.

Configuration
REQ-022 With macro SPRITE_ANIM_EN defined, frame number = base + ((frame_count >> ANIM_SHIFT) & (2^anim_log2 - 1)).
REQ-023 Without SPRITE_ANIM_EN, frame number = base; tbl_anim_log2 is ignored and its storage is not built.

Structure
REQ-024 SHALL place the sprite entry struct typedef, the FSM state enum, and the default canvas/frame constants in package sprite_pkg, which is shared with the rendering side.
REQ-025 SHALL be a single module with no sub-module; the table is an array of sprite_pkg entries.

Verification
REQ-026 Entries 0 and 3 active (x=10,y=20,base=5; x=100,y=200,base=40), sprite_ready=1, frame_count 0->1 -> exactly two transfers, (10,20,5) then (100,200,40); issued_count=2; busy falls.
REQ-027 Entry 1 at x=300 (>296) -> skipped, no transfer; issued_count=0.
REQ-028 sprite_ready held 0 for 50 cycles during ISSUE -> sprite_valid stays 1 with stable outputs; transfer on the cycle ready rises.
REQ-029 SPRITE_ANIM_EN, base=8, anim_log2=2, frame_count=13 -> frame_number=11; without the macro -> 8.
REQ-030 frame_count changes while the second of three sprites is pending -> overrun=1; walk restarts from entry 0; three transfers follow.
REQ-031 sys_rst pulsed while in ISSUE -> sprite_valid=0 next cycle; no transfers on later frame changes until the table is rewritten.
